// File: rtl/pipe_pkg.sv
// Shared helpers for the register pipeline: occupancy counter sizing.
package pipe_pkg;

   // Counter must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid bit plus data register; load wins over clear.
// Data changes only on load, so a cleared stage keeps its last value.
module pipe_stage #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic             vld,
   output logic [WIDTH-1:0] dat
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= 1'b0;
         dat <= RST_VAL;
      end else if (load) begin
         vld <= 1'b1;
         dat <= din;
      end else if (clear) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipeline, DEPTH cycles latency when unstalled.
// Empty stages ahead of a stall still advance; flush drops every valid bit.
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [DEPTH-1:0] load;
   logic [DEPTH:0]   rdy;
   logic             in_hs;
   logic             out_hs;

   // A stage is ready if any stage from it to the output is empty, or the sink is ready.
   always_comb begin
      logic acc;
      acc        = out_ready;
      rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc    = acc | ~v[i];
         rdy[i] = acc;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign src_v[g] = in_valid;
         assign src_d[g] = in_data;
      end else begin : g_body
         assign src_v[g] = v[g-1];
         assign src_d[g] = d[g-1];
      end

      assign load[g] = src_v[g] & rdy[g] & ~flush;

      pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .load  (load[g]),
         .clear (flush | rdy[g+1]),
         .din   (src_d[g]),
         .vld   (v[g]),
         .dat   (d[g])
      );
   end

   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_data  = d[DEPTH-1];

   assign in_hs  = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (in_hs && !out_hs) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (out_hs && !in_hs) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed scenarios then random traffic.
module tb_pipe_reg_chain;

   localparam int DEPTH = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] occupancy;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] exp_q [$];

   pipe_reg_chain #(.WIDTH(8), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: an ordered queue of accepted items. Occupancy is its size;
   // the chain can accept unless it holds DEPTH items with the sink stalled.
   always @(negedge clk) begin
      bit         exp_rdy;
      logic [7:0] exp_d;
      if (!rst) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_out_data", out_data, 8'h00);
         check("rst_occupancy", occupancy, 0);
         exp_q.delete();
      end else begin
         exp_rdy = !flush && ((exp_q.size() < DEPTH) || out_ready);
         check("occupancy", occupancy, exp_q.size());
         check("in_ready", in_ready, exp_rdy);
         if (flush) check("flush_out_valid", out_valid, 0);
         if (exp_q.size() == 0) check("empty_out_valid", out_valid, 0);
         if (out_valid && out_ready && !flush && exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            check("out_data", out_data, exp_d);
         end
         if (in_valid && exp_rdy) exp_q.push_back(in_data);
         if (flush) exp_q.delete();
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) cyc();
      rst = 1'b1;
      cyc();

      // Latency and throughput
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA1;
      cyc(); check("lat_ov_e1", out_valid, 0);
      in_data = 8'hA2;
      cyc(); check("lat_ov_e2", out_valid, 0);
      in_data = 8'hA3;
      cyc(); check("lat_ov_e3", out_valid, 1); check("lat_d_e3", out_data, 8'hA1); check("lat_occ_e3", occupancy, 3);
      in_data = 8'hA4;
      cyc(); check("lat_d_e4", out_data, 8'hA2); check("lat_occ_e4", occupancy, 3);
      in_valid = 1'b0;
      cyc(); check("lat_d_e5", out_data, 8'hA3); check("lat_occ_e5", occupancy, 2);
      cyc(); check("lat_d_e6", out_data, 8'hA4); check("lat_occ_e6", occupancy, 1);
      cyc(); check("lat_ov_e7", out_valid, 0); check("lat_occ_e7", occupancy, 0);

      // Backpressure and full
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'h11; cyc();
      in_data = 8'h22; cyc();
      in_data = 8'h33; cyc();
      in_data = 8'h44;
      check("full_in_ready", in_ready, 0); check("full_occ", occupancy, 3); check("full_d", out_data, 8'h11);
      out_ready = 1'b1; #1;
      check("full_pass_in_ready", in_ready, 1);
      cyc(); check("full_pass_d", out_data, 8'h22); check("full_pass_occ", occupancy, 3);
      in_valid = 1'b0;
      cyc(); check("full_drain_d1", out_data, 8'h33);
      cyc(); check("full_drain_d2", out_data, 8'h44);
      cyc(); check("full_drain_ov", out_valid, 0);

      // Bubble collapse behind a stalled output
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
      cyc(); in_valid = 1'b0;
      cyc(); cyc();
      check("bub_ov", out_valid, 1); check("bub_d55", out_data, 8'h55);
      in_valid = 1'b1; in_data = 8'h66;
      check("bub_in_ready", in_ready, 1);
      cyc(); in_valid = 1'b0;
      cyc(); check("bub_occ", occupancy, 2);
      out_ready = 1'b1;
      cyc(); check("bub_ov66", out_valid, 1); check("bub_d66", out_data, 8'h66); check("bub_occ1", occupancy, 1);
      cyc(); check("bub_empty", out_valid, 0);

      // Flush
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'h81; cyc();
      in_data = 8'h82; cyc();
      in_data = 8'h83; cyc();
      check("fl_occ3", occupancy, 3);
      flush = 1'b1; in_data = 8'h99; out_ready = 1'b1; #1;
      check("fl_in_ready", in_ready, 0); check("fl_out_valid", out_valid, 0);
      cyc(); flush = 1'b0; in_valid = 1'b0;
      check("fl_occ0", occupancy, 0); check("fl_ov0", out_valid, 0); check("fl_data_hold", out_data, 8'h81);
      in_valid = 1'b1; in_data = 8'h77;
      cyc(); in_valid = 1'b0;
      cyc(); check("fl77_ov_e2", out_valid, 0);
      cyc(); check("fl77_ov_e3", out_valid, 1); check("fl77_d", out_data, 8'h77);
      cyc(); check("fl77_empty", out_valid, 0);

      // Concurrent input and output starting from two items at the output end
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'hB1; cyc();
      in_data = 8'hB2; cyc();
      in_valid = 1'b0; cyc(); cyc();
      check("sim_occ_start", occupancy, 2); check("sim_d_start", out_data, 8'hB1);
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 8'hC0; cyc(); check("sim_occ1", occupancy, 2); check("sim_d1", out_data, 8'hB2);
      in_data = 8'hC1; cyc(); check("sim_occ2", occupancy, 2); check("sim_ov2", out_valid, 0);
      in_data = 8'hC2; cyc(); check("sim_occ3", occupancy, 3); check("sim_d3", out_data, 8'hC0);
      in_data = 8'hC3; cyc(); check("sim_occ4", occupancy, 3); check("sim_d4", out_data, 8'hC1);
      in_data = 8'hC4; cyc(); check("sim_occ5", occupancy, 3); check("sim_d5", out_data, 8'hC2);
      in_valid = 1'b0;
      repeat (4) cyc();
      check("sim_drained", occupancy, 0);

      // Reset with two items in flight
      in_valid = 1'b1; in_data = 8'hD1; cyc();
      in_data = 8'hD2; cyc();
      in_valid = 1'b0;
      #2 rst = 1'b0; #1;
      check("arst_ov", out_valid, 0); check("arst_d", out_data, 8'h00); check("arst_occ", occupancy, 0);
      cyc(); cyc();
      rst = 1'b1; #1;
      check("arst_rel_in_ready", in_ready, 1); check("arst_rel_occ", occupancy, 0);
      repeat (3) cyc();
      check("arst_no_ghost", out_valid, 0);

      // Random traffic
      repeat (1500) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         cyc();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (DEPTH + 3) cyc();
      check("final_drain", exp_q.size(), 0);
      check("final_occ", occupancy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
